// File: rtl/cnt_day_pkg.sv
// Shared calendar constants and BCD helpers for the day/month counter chain.
package cnt_day_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd_pair_t;

   // BCD month codes as {tens, ones}
   localparam bcd_pair_t M_JAN = 8'h01;
   localparam bcd_pair_t M_FEB = 8'h02;
   localparam bcd_pair_t M_MAR = 8'h03;
   localparam bcd_pair_t M_APR = 8'h04;
   localparam bcd_pair_t M_MAY = 8'h05;
   localparam bcd_pair_t M_JUN = 8'h06;
   localparam bcd_pair_t M_JUL = 8'h07;
   localparam bcd_pair_t M_AUG = 8'h08;
   localparam bcd_pair_t M_SEP = 8'h09;
   localparam bcd_pair_t M_OCT = 8'h10;
   localparam bcd_pair_t M_NOV = 8'h11;
   localparam bcd_pair_t M_DEC = 8'h12;

   // BCD day codes
   localparam bcd_pair_t D_01 = 8'h01;
   localparam bcd_pair_t D_28 = 8'h28;
   localparam bcd_pair_t D_29 = 8'h29;
   localparam bcd_pair_t D_30 = 8'h30;
   localparam bcd_pair_t D_31 = 8'h31;

   // Last-day lookup results
   localparam bcd_pair_t LAST_FEB      = D_28;
   localparam bcd_pair_t LAST_FEB_LEAP = D_29;
   localparam bcd_pair_t LAST_SHORT    = D_30;
   localparam bcd_pair_t LAST_LONG     = D_31;

   // Two-digit BCD increment; callers guarantee the result stays within 01..31
   function automatic bcd_pair_t bcd_day_inc(input bcd_pair_t d);
      if (d[3:0] == 4'd9)
         return {d[7:4] + 4'd1, 4'd0};
      else
         return {d[7:4], d[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/cnt_day_if.sv
// Control, month context and day outputs between the calendar chain and cnt_day.
interface cnt_day_if;
   import cnt_day_pkg::*;

   logic       ENABLE;
   logic       CARRY_in;
   logic       ADJ_UP;
   bcd_digit_t MONTH2;
   bcd_digit_t MONTH10;
   logic       LEAP;
   bcd_digit_t CNT2;
   bcd_digit_t CNT10;
   logic       CARRY_out;

   modport master (
      output ENABLE, CARRY_in, ADJ_UP, MONTH2, MONTH10, LEAP,
      input  CNT2, CNT10, CARRY_out
   );

   modport slave (
      input  ENABLE, CARRY_in, ADJ_UP, MONTH2, MONTH10, LEAP,
      output CNT2, CNT10, CARRY_out
   );

endinterface

// File: rtl/cnt_day_day_limit.sv
// Last day of the current month in BCD; anything that is not a legal month maps to 31.
module day_limit
   import cnt_day_pkg::*;
(
   input  bcd_digit_t MONTH2,
   input  bcd_digit_t MONTH10,
   input  logic       LEAP,
   output bcd_pair_t  LAST
);

   // Month-length lookup keyed on the raw BCD month code
   always_comb begin
      LAST = LAST_LONG;
      case ({MONTH2, MONTH10})
         M_FEB:                      LAST = LEAP ? LAST_FEB_LEAP : LAST_FEB;
         M_APR, M_JUN, M_SEP, M_NOV: LAST = LAST_SHORT;
         default:                    LAST = LAST_LONG;
      endcase
   end

endmodule

// File: rtl/cnt_day.sv
// BCD day-of-month counter: tick/adjust increment with month wrap, and clamp when the month shrinks.
module cnt_day
   import cnt_day_pkg::*;
#(
   parameter bcd_pair_t DAY_RESET = D_01
)
(
   input  logic      CLK,
   input  logic      RESET,
   cnt_day_if.slave  bus
);

   bcd_pair_t day_q;
   bcd_pair_t day_d;
   bcd_pair_t last;
   logic      at_last;

   day_limit u_day_limit (
      .MONTH2  (bus.MONTH2),
      .MONTH10 (bus.MONTH10),
      .LEAP    (bus.LEAP),
      .LAST    (last)
   );

   // Both operands are legal BCD, so a plain binary compare orders them correctly
   assign at_last = (day_q >= last);

   // Next day: tick beats adjust beats clamp; nothing moves without ENABLE
   always_comb begin
      day_d = day_q;
      if (bus.ENABLE) begin
         if (bus.CARRY_in || bus.ADJ_UP)
            day_d = at_last ? D_01 : bcd_day_inc(day_q);
         else if (day_q > last)
            day_d = last;
      end
   end

   // Day register, forced to DAY_RESET the moment RESET rises
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         day_q <= DAY_RESET;
      else
         day_q <= day_d;
   end

   assign bus.CNT2      = day_q[7:4];
   assign bus.CNT10     = day_q[3:0];
   // Month advance only on a real tick at the last day, never while in reset
   assign bus.CARRY_out = bus.ENABLE & bus.CARRY_in & at_last & ~RESET;

endmodule

// File: tb/tb_cnt_day.sv
// Self-checking bench for cnt_day: directed calendar scenarios plus randomized traffic
// compared against an integer day-of-month model.
module tb_cnt_day;

   logic CLK = 1'b0;
   logic RESET;
   logic co;
   logic [7:0] obs_day;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_day;

   always #5 CLK = ~CLK;

   cnt_day_if bus ();

   cnt_day dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   assign obs_day = {bus.CNT2, bus.CNT10};

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Month length from the calendar rules, in plain integers
   function automatic int ref_last(input logic [3:0] m2, input logic [3:0] m10, input logic leap);
      int m;
      if (m2 > 4'd9 || m10 > 4'd9) return 31;
      m = int'(m2) * 10 + int'(m10);
      if (m == 2) return leap ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic logic [7:0] to_bcd(input int d);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(d / 10);
      o = 4'(d % 10);
      return {t, o};
   endfunction

   // One clock: drive at negedge, check CARRY_out combinationally, step model at posedge, check day
   task automatic cycle(input logic en, input logic ci, input logic adj, output logic co_o);
      int  last;
      logic exp_co;
      @(negedge CLK);
      bus.ENABLE   = en;
      bus.CARRY_in = ci;
      bus.ADJ_UP   = adj;
      #1;
      last   = ref_last(bus.MONTH2, bus.MONTH10, bus.LEAP);
      exp_co = en && ci && (m_day >= last);
      co_o   = bus.CARRY_out;
      check("carry_out", {7'd0, co_o}, {7'd0, exp_co});
      @(posedge CLK);
      if (en) begin
         if (ci || adj)
            m_day = (m_day >= last) ? 1 : m_day + 1;
         else if (m_day > last)
            m_day = last;
      end
      #1;
      check("day", obs_day, to_bcd(m_day));
      bus.CARRY_in = 1'b0;
      bus.ADJ_UP   = 1'b0;
   endtask

   task automatic set_month(input logic [7:0] m, input logic leap);
      bus.MONTH2  = m[7:4];
      bus.MONTH10 = m[3:0];
      bus.LEAP    = leap;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      bus.ENABLE   = 1'b0;
      bus.CARRY_in = 1'b0;
      bus.ADJ_UP   = 1'b0;
      set_month(8'h01, 1'b0);
      RESET = 1'b1;
      m_day = 1;
      #2;
      check("reset_day", obs_day, 8'h01);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;

      // Count to 17, then reset asynchronously mid-cycle with a tick pending
      repeat (16) cycle(1'b1, 1'b1, 1'b0, co);
      check("day17", obs_day, 8'h17);
      @(negedge CLK);
      #2;
      bus.ENABLE   = 1'b1;
      bus.CARRY_in = 1'b1;
      RESET        = 1'b1;
      #1;
      check("async_reset", obs_day, 8'h01);
      check("reset_carry", {7'd0, bus.CARRY_out}, 8'd0);
      m_day = 1;
      @(posedge CLK);
      #1;
      check("reset_hold", obs_day, 8'h01);
      @(negedge CLK);
      RESET        = 1'b0;
      bus.CARRY_in = 1'b0;

      // Disabled ticks do nothing
      repeat (3) cycle(1'b0, 1'b1, 1'b0, co);
      check("disabled_hold", obs_day, 8'h01);
      check("disabled_carry", {7'd0, co}, 8'd0);

      // January: tens carry and month wrap
      repeat (8) cycle(1'b1, 1'b1, 1'b0, co);
      check("jan_09", obs_day, 8'h09);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("jan_10", obs_day, 8'h10);
      repeat (21) cycle(1'b1, 1'b1, 1'b0, co);
      check("jan_31", obs_day, 8'h31);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("jan_wrap_carry", {7'd0, co}, 8'd1);
      check("jan_wrap_day", obs_day, 8'h01);
      cycle(1'b1, 1'b0, 1'b0, co);
      check("jan_carry_one_cycle", {7'd0, co}, 8'd0);

      // February, common year then leap year
      set_month(8'h02, 1'b0);
      repeat (27) cycle(1'b1, 1'b1, 1'b0, co);
      check("feb_28", obs_day, 8'h28);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("feb_wrap_carry", {7'd0, co}, 8'd1);
      check("feb_wrap_day", obs_day, 8'h01);
      set_month(8'h02, 1'b1);
      repeat (27) cycle(1'b1, 1'b1, 1'b0, co);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("leap_29", obs_day, 8'h29);
      check("leap_29_carry", {7'd0, co}, 8'd0);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("leap_wrap_carry", {7'd0, co}, 8'd1);
      check("leap_wrap_day", obs_day, 8'h01);

      // April
      set_month(8'h04, 1'b0);
      repeat (28) cycle(1'b1, 1'b1, 1'b0, co);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("apr_30", obs_day, 8'h30);
      check("apr_30_carry", {7'd0, co}, 8'd0);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("apr_wrap_carry", {7'd0, co}, 8'd1);
      check("apr_wrap_day", obs_day, 8'h01);

      // Clamp when the month shrinks under the day
      set_month(8'h03, 1'b0);
      repeat (30) cycle(1'b1, 1'b0, 1'b1, co);
      check("mar_adj_31", obs_day, 8'h31);
      set_month(8'h02, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, co);
      check("clamp_feb", obs_day, 8'h28);
      set_month(8'h02, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, co);
      check("leap_adj_29", obs_day, 8'h29);
      set_month(8'h02, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, co);
      check("clamp_leap_drop", obs_day, 8'h28);
      set_month(8'h03, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b1, co);
      set_month(8'h04, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, co);
      check("clamp_waits_enable", obs_day, 8'h31);
      cycle(1'b1, 1'b0, 1'b0, co);
      check("clamp_apr", obs_day, 8'h30);

      // Adjust wraps without carrying; tick beats adjust
      set_month(8'h06, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, co);
      check("adj_wrap_day", obs_day, 8'h01);
      check("adj_wrap_carry", {7'd0, co}, 8'd0);
      repeat (4) cycle(1'b1, 1'b0, 1'b1, co);
      cycle(1'b1, 1'b1, 1'b1, co);
      check("both_pulses_day", obs_day, 8'h06);
      check("both_pulses_carry", {7'd0, co}, 8'd0);

      // Out-of-range month behaves as a 31-day month
      set_month(8'h13, 1'b0);
      repeat (25) cycle(1'b1, 1'b0, 1'b1, co);
      check("m13_31", obs_day, 8'h31);
      cycle(1'b1, 1'b1, 1'b0, co);
      check("m13_wrap_carry", {7'd0, co}, 8'd1);
      check("m13_wrap_day", obs_day, 8'h01);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.MONTH2  = 4'($urandom_range(0, 15));
               bus.MONTH10 = 4'($urandom_range(0, 15));
            end else begin
               bus.MONTH2  = 4'($urandom_range(0, 1));
               bus.MONTH10 = 4'($urandom_range(0, 9));
            end
         end
         if ($urandom_range(0, 19) == 0)
            bus.LEAP = ~bus.LEAP;
         cycle(1'($urandom_range(0, 9) != 0),
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 5) == 0), co);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cnt_day.md
Name: cnt_day

Overview:
- BCD day-of-month counter for the calendar chain.
- Sits between the hour/day-rollover stage, which drives CARRY_in, and the month counter, which receives CARRY_out as its CARRY_in.
- Counts 01..last day of the current month. The last day comes from the month counter's BCD outputs and a leap-year flag.
- Also supports manual increment for time-setting, and clamps the day when the month length shrinks under it.

Parameters:
- DAY_RESET, 8'h01, BCD day loaded on reset; must be 01..28.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  clock enable; gates every state update and CARRY_out.
- CARRY_in  input  1  day-advance pulse from upstream stage, one CLK wide.
- ADJ_UP  input  1  manual increment pulse (setting mode), one CLK wide.
- MONTH2  input  4  BCD month tens (0..1), from month counter.
- MONTH10  input  4  BCD month ones (0..9), from month counter.
- LEAP  input  1  1 = current year is a leap year.
- CNT2  output  4  BCD day tens, 0..3.
- CNT10  output  4  BCD day ones, 0..9.
- CARRY_out  output  1  combinational; month-advance pulse to month counter.

Behaviour:
- Reset: RESET=1 forces {CNT2,CNT10}=DAY_RESET (default 01) immediately, with no clock needed. CARRY_out=0 while the counter sits at reset value below LAST.
- LAST (combinational, from {MONTH2,MONTH10}):
  - 02 → 29 if LEAP else 28.
  - 04, 06, 09, 11 → 30.
  - 01, 03, 05, 07, 08, 10, 12 → 31.
  - Any non-BCD or out-of-range month (00, 13+, nibble>9) → 31.
- DAY denotes {CNT2,CNT10}. Comparisons are BCD-as-binary 8-bit compares, which are valid because both operands are legal BCD.
- CARRY_out = ENABLE & CARRY_in & (DAY >= LAST). Zero latency, same cycle as the tick.
- Priority per rising CLK, applying only when ENABLE=1:
  1. Tick (CARRY_in=1): if DAY >= LAST, DAY ← 01. Else BCD increment: CNT10=9 → CNT10←0 and CNT2←CNT2+1; otherwise CNT10←CNT10+1.
  2. Adjust (ADJ_UP=1, CARRY_in=0): same increment/wrap as tick. CARRY_out stays 0, so the month is unaffected.
  3. Clamp (neither pulse, DAY > LAST): DAY ← LAST. This covers month/leap changes, e.g. day 31 with month set to 04 gives 30 next cycle.
  4. Otherwise hold.
- ENABLE=0: hold all state; CARRY_out=0. A pending clamp waits for ENABLE.
- Simultaneous CARRY_in and ADJ_UP: tick wins and ADJ_UP is dropped.
- Wrap and month change are coincident. The month counter advances on the same edge DAY goes 01, so the next month's LAST applies from the following cycle.
- DAY never leaves 01..31 and never shows 00. CNT10 never exceeds 9.
- RESET mid-operation aborts any tick or clamp; no CARRY_out is produced once RESET is high.

Decomposition:
- Shared calendar package holds:
  - BCD month constants (M_JAN..M_DEC).
  - Day constants D_01, D_28, D_29, D_30, D_31.
  - Last-day lookup constants.
- Separate combinational sub-module day_limit: (MONTH2, MONTH10, LEAP) → LAST[7:0] BCD. It will be reused by the setting-mode display logic.
- cnt_day instantiates day_limit and holds the counter, priority mux and clamp.

Test Plan:
- Reset/hold: assert RESET mid-count at day 17 → outputs 01 asynchronously. ENABLE=0 with CARRY_in pulses → stays 01, CARRY_out=0.
- 31-day month: month=01, ticks from 01 → 09, 10 (tens carry), then 31. Next tick → 01 with CARRY_out=1 for exactly that cycle.
- February: month=02, LEAP=0, day 28 + tick → 01, CARRY_out=1. LEAP=1: 28 → 29, then 29 → 01 with CARRY_out=1.
- 30-day month: month=04, day 30 + tick → 01, CARRY_out=1. Day 29 + tick → 30, CARRY_out=0.
- Clamp: day 31 (month 03), change month to 02, LEAP=0, no pulses → day 28 after one CLK. Change LEAP 1→0 at day 29 (month 02) → 28.
- Adjust and priority: month=06, day 30 + ADJ_UP → 01, CARRY_out=0. Day 05 with CARRY_in and ADJ_UP together → 06 (single increment), CARRY_out=0. Invalid month 8'h13 at day 31 + tick → 01, CARRY_out=1.
